trees_acc_stream_ctrl: RTL and testbench

- Stream-side initiator for the tree-ensemble ping-pong accelerator.
- Tree-load command: accepts 64-bit words from a DMA read stream and writes them into the accelerator's tree memory.
- Inference command: writes feature words into the accelerator's feature memory, pulses start, waits for done, then reads packed predictions back and emits them on a 64-bit output stream toward DMA write.

---
 rtl/trees_acc_stream_ctrl_if.sv | 20 ++
 rtl/trees_acc_stream_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_trees_acc_stream_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trees_acc_stream_ctrl_if.sv
// Stream bundle between DMA and the tree-ensemble stream controller.
// The controller consumes the in-stream and produces the out-stream.
interface trees_acc_stream_ctrl_if;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/trees_acc_stream_ctrl.sv
// Stream-side initiator for the tree-ensemble accelerator: loads trees or features
// from the input stream, runs one inference and streams packed predictions back out.
module trees_acc_stream_ctrl #(
  parameter int unsigned N_TREES          = 16,
  parameter int unsigned N_NODE_AND_LEAFS = 256,
  parameter int unsigned N_FEATURE        = 32,
  parameter int unsigned MAX_BURST        = 5000,
  localparam int unsigned BL_W = $clog2(MAX_BURST) + 1,
  localparam int unsigned NT_W = $clog2(N_TREES),
  localparam int unsigned NN_W = $clog2(N_NODE_AND_LEAFS),
  localparam int unsigned FA_W = $clog2(MAX_BURST * N_FEATURE / 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_load_trees,
  input  logic [BL_W-1:0]      cfg_burst_len,
  trees_acc_stream_ctrl_if.slave strm,
  output logic                 busy,
  output logic                 cmd_done,
  output logic                 acc_load_trees,
  output logic [NT_W-1:0]      acc_n_tree,
  output logic [NN_W-1:0]      acc_n_node,
  output logic [63:0]          acc_tree_nodes,
  output logic                 acc_load_features,
  output logic [FA_W-1:0]      acc_feature_addr,
  output logic [63:0]          acc_features2,
  output logic [BL_W-1:0]      acc_burst_len,
  output logic                 acc_start,
  input  logic                 acc_done,
  output logic [BL_W-1:0]      acc_prediction_addr,
  input  logic [63:0]          acc_prediction
);

  localparam int unsigned TREE_WORDS = N_TREES * N_NODE_AND_LEAFS;
  localparam int unsigned FEAT_WORDS = MAX_BURST * N_FEATURE / 2;
  localparam int unsigned CNT_MAX    = (TREE_WORDS > FEAT_WORDS) ? TREE_WORDS : FEAT_WORDS;
  localparam int unsigned CW         = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOADT, S_LOADF, S_STRT, S_RUN, S_READ, S_SEND, S_FIN
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_expect;
  logic [BL_W-1:0]   r_len;
  logic [BL_W-1:0]   r_nwords;
  logic [BL_W-1:0]   r_pred_addr;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [63:0]       r_out_data;
  logic              r_busy;
  logic              r_cmd_done;
  logic              r_load_trees;
  logic [NT_W-1:0]   r_n_tree;
  logic [NN_W-1:0]   r_n_node;
  logic [63:0]       r_tree_nodes;
  logic              r_load_features;
  logic [FA_W-1:0]   r_feature_addr;
  logic [63:0]       r_features2;
  logic              r_acc_start;

  logic [BL_W-1:0]   w_len_clamped;
  logic              w_in_hs;
  logic              w_last_in;
  logic              w_out_hs;
  logic              w_last_out;
  logic [2:0]        w_tail;
  logic [63:0]       w_byte_mask;

  assign w_len_clamped = (cfg_burst_len > BL_W'(MAX_BURST)) ? BL_W'(MAX_BURST) : cfg_burst_len;
  assign w_in_hs       = strm.in_valid && r_in_ready;
  assign w_last_in     = (r_cnt + CW'(1)) == r_expect;
  assign w_out_hs      = r_out_valid && strm.out_ready;
  assign w_last_out    = (r_pred_addr + BL_W'(1)) == r_nwords;
  assign w_tail        = r_len[2:0];

  // Bytes past the final sample of a partial last word carry no prediction.
  always_comb begin
    w_byte_mask = '1;
    if (w_last_out && (w_tail != 3'd0)) begin
      for (int i = 0; i < 8; i++) begin
        if (3'(i) >= w_tail) w_byte_mask[8*i +: 8] = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_expect        <= '0;
      r_len           <= '0;
      r_nwords        <= '0;
      r_pred_addr     <= '0;
      r_in_ready      <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_data      <= '0;
      r_busy          <= 1'b0;
      r_cmd_done      <= 1'b0;
      r_load_trees    <= 1'b0;
      r_n_tree        <= '0;
      r_n_node        <= '0;
      r_tree_nodes    <= '0;
      r_load_features <= 1'b0;
      r_feature_addr  <= '0;
      r_features2     <= '0;
      r_acc_start     <= 1'b0;
    end else begin
      r_load_trees    <= 1'b0;
      r_load_features <= 1'b0;
      r_acc_start     <= 1'b0;
      r_cmd_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_busy   <= 1'b1;
            r_len    <= w_len_clamped;
            r_nwords <= (w_len_clamped + BL_W'(7)) >> 3;
            r_cnt    <= '0;
            r_expect <= cfg_load_trees ? CW'(TREE_WORDS)
                                       : CW'(w_len_clamped) * CW'(N_FEATURE / 2);
            if (cfg_load_trees) begin
              r_in_ready <= 1'b1;
              r_state    <= S_LOADT;
            end else if (w_len_clamped == '0) begin
              r_state    <= S_FIN;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= S_LOADF;
            end
          end
        end
        S_LOADT: begin
          if (w_in_hs) begin
            r_load_trees <= 1'b1;
            r_n_tree     <= NT_W'(r_cnt / CW'(N_NODE_AND_LEAFS));
            r_n_node     <= NN_W'(r_cnt % CW'(N_NODE_AND_LEAFS));
            r_tree_nodes <= strm.in_data;
            r_cnt        <= r_cnt + CW'(1);
            if (w_last_in) begin
              r_in_ready <= 1'b0;
              r_state    <= S_FIN;
            end
          end
        end
        S_LOADF: begin
          if (w_in_hs) begin
            r_load_features <= 1'b1;
            r_feature_addr  <= FA_W'(r_cnt);
            r_features2     <= strm.in_data;
            r_cnt           <= r_cnt + CW'(1);
            if (w_last_in) begin
              r_in_ready <= 1'b0;
              r_state    <= S_STRT;
            end
          end
        end
        S_STRT: begin
          r_acc_start <= 1'b1;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (acc_done) begin
            r_pred_addr <= '0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_out_data  <= acc_prediction & w_byte_mask;
          r_out_valid <= 1'b1;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            if (w_last_out) begin
              r_state <= S_FIN;
            end else begin
              r_pred_addr <= r_pred_addr + BL_W'(1);
              r_state     <= S_READ;
            end
          end
        end
        S_FIN: begin
          r_cmd_done <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign strm.in_ready       = r_in_ready;
  assign strm.out_data       = r_out_data;
  assign strm.out_valid      = r_out_valid;
  assign busy                = r_busy;
  assign cmd_done            = r_cmd_done;
  assign acc_load_trees      = r_load_trees;
  assign acc_n_tree          = r_n_tree;
  assign acc_n_node          = r_n_node;
  assign acc_tree_nodes      = r_tree_nodes;
  assign acc_load_features   = r_load_features;
  assign acc_feature_addr    = r_feature_addr;
  assign acc_features2       = r_features2;
  assign acc_burst_len       = r_len;
  assign acc_start           = r_acc_start;
  assign acc_prediction_addr = r_pred_addr;

endmodule

// File: tb/tb_trees_acc_stream_ctrl.sv
// Directed bench for trees_acc_stream_ctrl: a queue-based reference of expected
// accelerator writes and output words, checked every cycle by one monitor.
module tb_trees_acc_stream_ctrl;
  localparam int unsigned BL_W = 14;
  localparam int unsigned NT_W = 4;
  localparam int unsigned NN_W = 8;
  localparam int unsigned FA_W = 17;

  typedef struct packed {
    logic [NT_W-1:0] t;
    logic [NN_W-1:0] n;
    logic [63:0]     d;
  } tw_t;

  typedef struct packed {
    logic [FA_W-1:0] a;
    logic [63:0]     d;
  } fw_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_load_trees = 1'b0;
  logic [BL_W-1:0]   cfg_burst_len = '0;
  logic              busy, cmd_done;
  logic              acc_load_trees, acc_load_features, acc_start;
  logic [NT_W-1:0]   acc_n_tree;
  logic [NN_W-1:0]   acc_n_node;
  logic [63:0]       acc_tree_nodes, acc_features2, acc_prediction;
  logic [FA_W-1:0]   acc_feature_addr;
  logic [BL_W-1:0]   acc_burst_len, acc_prediction_addr;
  logic              acc_done = 1'b0;
  logic [63:0]       pred_mem [8];

  trees_acc_stream_ctrl_if bus ();

  trees_acc_stream_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_start           (cfg_start),
    .cfg_load_trees      (cfg_load_trees),
    .cfg_burst_len       (cfg_burst_len),
    .strm                (bus.slave),
    .busy                (busy),
    .cmd_done            (cmd_done),
    .acc_load_trees      (acc_load_trees),
    .acc_n_tree          (acc_n_tree),
    .acc_n_node          (acc_n_node),
    .acc_tree_nodes      (acc_tree_nodes),
    .acc_load_features   (acc_load_features),
    .acc_feature_addr    (acc_feature_addr),
    .acc_features2       (acc_features2),
    .acc_burst_len       (acc_burst_len),
    .acc_start           (acc_start),
    .acc_done            (acc_done),
    .acc_prediction_addr (acc_prediction_addr),
    .acc_prediction      (acc_prediction)
  );

  always #5 clk = ~clk;

  assign acc_prediction = (acc_prediction_addr < BL_W'(8)) ? pred_mem[acc_prediction_addr[2:0]]
                                                           : 64'hBAD0_BAD0_BAD0_BAD0;

  int n_cmp = 0, n_fail = 0;
  int n_tree_wr = 0, n_feat_wr = 0, n_start = 0, n_out = 0, n_done = 0;
  int o_idx = 0, exp_len = 0, out_mode = 0, done_delay = 4;
  int w300_tree = -1, w300_node = -1;
  logic [63:0] last_out = '0;
  tw_t         tq[$];
  fw_t         fq[$];
  logic [63:0] oq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Prediction word r as the output stream must carry it for an L-sample burst.
  function automatic logic [63:0] exp_word(input int len, input int r);
    logic [63:0] w;
    int tail;
    w    = pred_mem[r];
    tail = len % 8;
    if (r == (len + 7) / 8 - 1 && tail != 0) w = w & ((64'd1 << (8 * tail)) - 64'd1);
    return w;
  endfunction

  task automatic model_features(input int len, input logic [63:0] base);
    fw_t e;
    fq.delete();
    oq.delete();
    o_idx = 0;
    for (int k = 0; k < len * 16; k++) begin
      e.a = FA_W'(k);
      e.d = base + 64'(k);
      fq.push_back(e);
    end
    for (int r = 0; r < (len + 7) / 8; r++) oq.push_back(exp_word(len, r));
  endtask

  // Accelerator: done pulse a few cycles after start.
  always begin
    @(negedge clk);
    if (rst_n && acc_start) begin
      repeat (done_delay) @(posedge clk);
      #1 acc_done = 1'b1;
      @(posedge clk);
      #1 acc_done = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (out_mode == 1) bus.out_ready = ~bus.out_ready;
    else               bus.out_ready = 1'b1;
  end

  logic        prev_ov = 1'b0, prev_or = 1'b0;
  logic [63:0] prev_od = '0;

  always @(negedge clk) begin
    tw_t te;
    fw_t fe;
    if (!rst_n) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (acc_load_trees) begin
        n_tree_wr++;
        if (acc_tree_nodes == 64'd300) begin
          w300_tree = int'(acc_n_tree);
          w300_node = int'(acc_n_node);
        end
        if (tq.size() == 0) chk("tree_unexpected", 64'(acc_tree_nodes), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          te = tq.pop_front();
          chk("tree_idx", 64'({acc_n_tree, acc_n_node}), 64'({te.t, te.n}));
          chk("tree_data", acc_tree_nodes, te.d);
        end
      end
      if (acc_load_features) begin
        n_feat_wr++;
        if (fq.size() == 0) chk("feat_unexpected", 64'(acc_feature_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          fe = fq.pop_front();
          chk("feat_addr", 64'(acc_feature_addr), 64'(fe.a));
          chk("feat_data", acc_features2, fe.d);
        end
      end
      if (acc_start) begin
        n_start++;
        chk("start_after_feats", 64'(fq.size()), 64'd0);
      end
      if (prev_ov && !prev_or) begin
        chk("out_valid_held", 64'(bus.out_valid), 64'd1);
        chk("out_stable", bus.out_data, prev_od);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("pred_addr", 64'(acc_prediction_addr), 64'(o_idx));
        if (oq.size() == 0) chk("out_unexpected", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("out_data", bus.out_data, oq.pop_front());
        o_idx++;
        n_out++;
        last_out = bus.out_data;
      end
      if (cmd_done) n_done++;
      if (busy) chk("burst_len", 64'(acc_burst_len), 64'(exp_len));
      prev_ov = bus.out_valid;
      prev_or = bus.out_ready;
      prev_od = bus.out_data;
    end
  end

  task automatic pulse_cmd(input logic lt, input int len);
    @(negedge clk);
    cfg_start      = 1'b1;
    cfg_load_trees = lt;
    cfg_burst_len  = BL_W'(len);
    @(negedge clk);
    cfg_start      = 1'b0;
  endtask

  task automatic send_words(input int n, input int gap_mode, input logic [63:0] base);
    int k, guard, gap;
    k = 0; guard = 0; gap = 0;
    while (k < n && guard < n * 6 + 200) begin
      @(negedge clk);
      guard++;
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        gap--;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = base + 64'(k);
        if (bus.in_ready) begin
          k++;
          if (gap_mode != 0) gap = (k % 3) + 1;
        end
      end
    end
    if (k < n) chk("send_timeout", 64'(k), 64'(n));
  endtask

  task automatic wait_done(input int d0, input int budget);
    int c;
    c = 0;
    while (n_done == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (n_done == d0) chk("cmd_done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  int d0, s0, o0, f0, t0, c;

  initial begin
    tw_t e;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 8; i++) pred_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_cmd_done", 64'(cmd_done), 64'd0);
    chk("rst_acc_start", 64'(acc_start), 64'd0);
    chk("rst_strobes", 64'({acc_load_trees, acc_load_features}), 64'd0);
    chk("rst_burst_len", 64'(acc_burst_len), 64'd0);
    rst_n = 1'b1;

    // Tree load, in_valid held high with in_data = word index.
    exp_len = 0;
    for (int k = 0; k < 4096; k++) begin
      e.t = NT_W'(k / 256);
      e.n = NN_W'(k % 256);
      e.d = 64'(k);
      tq.push_back(e);
    end
    d0 = n_done; t0 = n_tree_wr;
    pulse_cmd(1'b1, 0);
    send_words(4096, 0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 64'(4096 + i);
      chk("tree_ready_low_after_last", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    wait_done(d0, 50);
    repeat (3) @(negedge clk);
    chk("tree_strobe_count", 64'(n_tree_wr - t0), 64'd4096);
    chk("tree_queue_drained", 64'(tq.size()), 64'd0);
    chk("tree_w300_tree", 64'(w300_tree), 64'd1);
    chk("tree_w300_node", 64'(w300_node), 64'd44);
    chk("tree_done_once", 64'(n_done - d0), 64'd1);
    chk("tree_idle", 64'(busy), 64'd0);

    // Inference L=3 with an all-ones prediction word.
    pred_mem[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_len = 3;
    model_features(3, 64'hA5A5_0000_0000_0000);
    d0 = n_done; s0 = n_start; o0 = n_out; f0 = n_feat_wr;
    pulse_cmd(1'b0, 3);
    send_words(48, 0, 64'hA5A5_0000_0000_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(d0, 200);
    repeat (3) @(negedge clk);
    chk("l3_feat_count", 64'(n_feat_wr - f0), 64'd48);
    chk("l3_start_once", 64'(n_start - s0), 64'd1);
    chk("l3_out_count", 64'(n_out - o0), 64'd1);
    chk("l3_out_word", last_out, 64'h0000_0000_00FF_FFFF);
    chk("l3_done_once", 64'(n_done - d0), 64'd1);

    // Inference L=17, gapped input, out_ready toggling.
    pred_mem[0] = 64'h1111_2222_3333_4444;
    pred_mem[1] = 64'h5555_6666_7777_8888;
    pred_mem[2] = 64'h8877_6655_4433_2211;
    exp_len = 17;
    out_mode = 1;
    model_features(17, 64'h0F00_0000_0000_0000);
    d0 = n_done; s0 = n_start; o0 = n_out; f0 = n_feat_wr;
    pulse_cmd(1'b0, 17);
    send_words(272, 1, 64'h0F00_0000_0000_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(d0, 300);
    out_mode = 0;
    repeat (3) @(negedge clk);
    chk("l17_feat_count", 64'(n_feat_wr - f0), 64'd272);
    chk("l17_start_once", 64'(n_start - s0), 64'd1);
    chk("l17_out_count", 64'(n_out - o0), 64'd3);
    chk("l17_last_word", last_out, 64'h0000_0000_0000_0011);

    // Zero-length inference.
    exp_len = 0;
    d0 = n_done; s0 = n_start; o0 = n_out;
    @(negedge clk);
    cfg_start = 1'b1; cfg_load_trees = 1'b0; cfg_burst_len = '0;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("l0_done_c1", 64'(cmd_done), 64'd0);
    chk("l0_in_ready", 64'(bus.in_ready), 64'd0);
    chk("l0_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("l0_done_c2", 64'(cmd_done), 64'd1);
    chk("l0_busy_c2", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("l0_no_start", 64'(n_start - s0), 64'd0);
    chk("l0_no_out", 64'(n_out - o0), 64'd0);
    chk("l0_done_once", 64'(n_done - d0), 64'd1);

    // cfg_start while waiting for acc_done is ignored.
    pred_mem[0] = 64'hDEAD_BEEF_CAFE_F00D;
    exp_len = 1;
    done_delay = 30;
    model_features(1, 64'h7700_0000_0000_0000);
    d0 = n_done; s0 = n_start; o0 = n_out; t0 = n_tree_wr;
    pulse_cmd(1'b0, 1);
    send_words(16, 0, 64'h7700_0000_0000_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    c = 0;
    while (n_start == s0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    chk("run_start_seen", 64'(n_start - s0), 64'd1);
    @(negedge clk);
    cfg_start = 1'b1; cfg_load_trees = 1'b1; cfg_burst_len = BL_W'(5);
    @(negedge clk);
    cfg_start = 1'b0;
    chk("run_ignore_busy", 64'(busy), 64'd1);
    chk("run_ignore_ready", 64'(bus.in_ready), 64'd0);
    wait_done(d0, 200);
    repeat (5) @(negedge clk);
    chk("run_done_once", 64'(n_done - d0), 64'd1);
    chk("run_no_tree_wr", 64'(n_tree_wr - t0), 64'd0);
    chk("run_out_count", 64'(n_out - o0), 64'd1);
    chk("run_out_word", last_out, 64'h0000_0000_0000_000D);
    chk("run_idle", 64'(busy), 64'd0);
    done_delay = 4;

    // Reset in the middle of a feature load.
    exp_len = 2;
    model_features(2, 64'h3300_0000_0000_0000);
    d0 = n_done; f0 = n_feat_wr;
    pulse_cmd(1'b0, 2);
    send_words(10, 0, 64'h3300_0000_0000_0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    bus.in_valid = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_strobes", 64'({acc_load_trees, acc_load_features, acc_start}), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_burst_len", 64'(acc_burst_len), 64'd0);
    fq.delete();
    oq.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_feat_count", 64'(n_feat_wr - f0), 64'd9);
    chk("mid_rst_no_done", 64'(n_done - d0), 64'd0);
    rst_n = 1'b1;

    // Fresh command after reset completes normally.
    pred_mem[0] = 64'h0123_4567_89AB_CDEF;
    exp_len = 1;
    model_features(1, 64'h4400_0000_0000_0000);
    d0 = n_done; s0 = n_start; o0 = n_out; f0 = n_feat_wr;
    pulse_cmd(1'b0, 1);
    send_words(16, 0, 64'h4400_0000_0000_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(d0, 200);
    repeat (3) @(negedge clk);
    chk("post_rst_feat_count", 64'(n_feat_wr - f0), 64'd16);
    chk("post_rst_start_once", 64'(n_start - s0), 64'd1);
    chk("post_rst_out_word", last_out, 64'h0000_0000_0000_00EF);
    chk("post_rst_out_count", 64'(n_out - o0), 64'd1);
    chk("post_rst_done_once", 64'(n_done - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
